// File: rtl/product_accumulator_pkg.sv
// Shared FSM encoding and default sizing for the product accumulator.
// Saturating accumulate is enabled by PRODUCT_ACCUMULATOR_SATURATE_EN.
package product_accumulator_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_GUARD = 8;
    localparam int DEF_LEN   = 8;

endpackage

// File: rtl/product_accumulator_acc_adder.sv
// Accumulator add with carry-out; clamps to all-ones on carry when
// PRODUCT_ACCUMULATOR_SATURATE_EN is defined, otherwise wraps.
module acc_adder
    import product_accumulator_pkg::*;
#(
    parameter int AW = 2*DEF_WIDTH + DEF_GUARD
) (
    input  logic [AW-1:0] acc,
    input  logic [AW-1:0] prod,
    output logic [AW-1:0] sum,
    output logic          carry
);

    logic [AW:0] raw;

    assign raw   = {1'b0, acc} + {1'b0, prod};
    assign carry = raw[AW];

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    // Once clamped, any further nonzero product carries again, so acc stays pinned.
    assign sum = carry ? {AW{1'b1}} : raw[AW-1:0];
`else
    assign sum = raw[AW-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// Frames unsigned products into sums of up to LEN terms with a sticky overflow flag.
// Optional saturation via PRODUCT_ACCUMULATOR_SATURATE_EN (see acc_adder).
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GUARD = DEF_GUARD,
    parameter int LEN   = DEF_LEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2*WIDTH-1:0]       in_prod,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*WIDTH+GUARD-1:0] out_sum,
    output logic [7:0]               out_cnt,
    output logic                     out_ovf
);

    localparam int AW = 2*WIDTH + GUARD;
    localparam logic [7:0] LEN_C = 8'(LEN);

    state_t          state, state_nx;
    logic [AW-1:0]   acc, base, sum;
    logic [7:0]      cnt, cnt_inc;
    logic            ovf, carry, accept, close;

    assign accept  = in_valid & in_ready;
    // An accept while in HOLD starts a fresh frame, so add onto zero.
    assign base    = (state == HOLD) ? '0 : acc;
    assign cnt_inc = ((state == HOLD) ? 8'd0 : cnt) + 8'd1;
    assign close   = in_last | (cnt_inc == LEN_C);

    acc_adder #(.AW(AW)) u_add (
        .acc   (base),
        .prod  (AW'(in_prod)),
        .sum   (sum),
        .carry (carry)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ACC;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ACC:  if (accept && close) state_nx = HOLD;
            HOLD: if (out_ready)       state_nx = (accept && close) ? HOLD : ACC;
            default: state_nx = ACC;
        endcase
    end

    always_comb begin
        out_valid = (state == HOLD);
        in_ready  = (state == ACC) | out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= 8'd0;
            ovf <= 1'b0;
        end else if (accept) begin
            acc <= sum;
            cnt <= cnt_inc;
            ovf <= ((state == HOLD) ? 1'b0 : ovf) | carry;
        end else if (state == HOLD && out_ready) begin
            acc <= '0;
            cnt <= 8'd0;
            ovf <= 1'b0;
        end
    end

    assign out_sum = acc;
    assign out_cnt = cnt;
    assign out_ovf = ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench: stimulus pushes expected frames, monitors pop on out handshake.
module tb_product_accumulator;

    typedef struct packed {
        logic [39:0] sum;
        logic [7:0]  cnt;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        v0 = 1'b0, l0 = 1'b0, r0 = 1'b1;
    logic [31:0] p0 = '0;
    logic        rdy0, ov0, of0;
    logic [39:0] s0;
    logic [7:0]  c0;

    logic        v1 = 1'b0, l1 = 1'b0, r1 = 1'b1;
    logic [31:0] p1 = '0;
    logic        rdy1, ov1, of1;
    logic [32:0] s1;
    logic [7:0]  c1;

    int checks = 0;
    int failures = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    product_accumulator #(.WIDTH(16), .GUARD(8), .LEN(4)) u0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0), .in_prod(p0), .in_last(l0),
        .out_valid(ov0), .out_ready(r0), .out_sum(s0), .out_cnt(c0), .out_ovf(of0)
    );

    product_accumulator #(.WIDTH(16), .GUARD(1), .LEN(4)) u1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_prod(p1), .in_last(l1),
        .out_valid(ov1), .out_ready(r1), .out_sum(s1), .out_cnt(c1), .out_ovf(of1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mon_cmp(input string name, input exp_t e, input logic [39:0] s,
                           input logic [7:0] c, input logic f);
        checks++;
        if (s !== e.sum || c !== e.cnt || f !== e.ovf) begin
            failures++;
            $display("FAIL %s: got sum=%0h cnt=%0d ovf=%0b expected sum=%0h cnt=%0d ovf=%0b",
                     name, s, c, f, e.sum, e.cnt, e.ovf);
        end
    endtask

    always @(negedge clk) begin
        if (ov0 === 1'b1 && r0 === 1'b1) begin
            if (q0.size() == 0) begin
                checks++; failures++;
                $display("FAIL frame0_unexpected: got sum=%0h cnt=%0d expected no frame", s0, c0);
            end else begin
                mon_cmp("frame0", q0.pop_front(), s0, c0, of0);
            end
        end
    end

    always @(negedge clk) begin
        if (ov1 === 1'b1 && r1 === 1'b1) begin
            if (q1.size() == 0) begin
                checks++; failures++;
                $display("FAIL frame1_unexpected: got sum=%0h cnt=%0d expected no frame", s1, c1);
            end else begin
                mon_cmp("frame1", q1.pop_front(), {7'd0, s1}, c1, of1);
            end
        end
    end

    task automatic send0(input logic [31:0] p, input logic l);
        int n = 0;
        v0 = 1'b1; p0 = p; l0 = l;
        @(negedge clk);
        while (!rdy0 && n < 50) begin @(negedge clk); n++; end
        if (!rdy0) begin
            checks++; failures++;
            $display("FAIL send0_timeout: got in_ready=0 expected 1 within 50 cycles");
        end else begin
            @(posedge clk); #1;
        end
        v0 = 1'b0; l0 = 1'b0;
    endtask

    task automatic send1(input logic [31:0] p, input logic l);
        int n = 0;
        v1 = 1'b1; p1 = p; l1 = l;
        @(negedge clk);
        while (!rdy1 && n < 50) begin @(negedge clk); n++; end
        if (!rdy1) begin
            checks++; failures++;
            $display("FAIL send1_timeout: got in_ready=0 expected 1 within 50 cycles");
        end else begin
            @(posedge clk); #1;
        end
        v1 = 1'b0; l1 = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [32:0] exp_ovf_sum;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_out_valid", ov0, 0);
        chk("reset_in_ready", rdy0, 1);
        chk("reset_sum", s0, 0);
        chk("reset_cnt", c0, 0);

        // Full-length frame, 1-cycle latency
        q0.push_back('{sum: 40'd26, cnt: 8'd4, ovf: 1'b0});
        send0(3, 0); send0(5, 0); send0(7, 0);
        chk("pre_close_out_valid", ov0, 0);
        send0(11, 0);
        chk("latency_out_valid", ov0, 1);
        @(posedge clk); #1;

        // Early close with backpressure, hold stability, then consume + accept
        r0 = 1'b0;
        q0.push_back('{sum: 40'd30, cnt: 8'd2, ovf: 1'b0});
        send0(10, 0); send0(20, 1);
        chk("hold_out_valid", ov0, 1);
        chk("hold_in_ready", rdy0, 0);
        for (int i = 0; i < 5; i++) begin
            v0 = 1'b1;
            p0 = i[0] ? 32'h5555AAAA : 32'hAAAA5555;
            @(posedge clk); #1;
            chk("stable_sum", s0, 30);
            chk("stable_cnt", c0, 2);
            chk("stable_ovf", of0, 0);
            chk("stable_in_ready", rdy0, 0);
        end
        v0 = 1'b0;
        r0 = 1'b1;
        q0.push_back('{sum: 40'd12, cnt: 8'd3, ovf: 1'b0});
        send0(9, 0);
        chk("restart_out_valid", ov0, 0);
        chk("restart_sum", s0, 9);
        chk("restart_cnt", c0, 1);
        send0(1, 0); send0(2, 1);
        @(posedge clk); #1;

        // Reset mid-frame discards partial sum
        send0(5, 0); send0(6, 0);
        pulse_rst();
        chk("rst_mid_out_valid", ov0, 0);
        chk("rst_mid_sum", s0, 0);
        q0.push_back('{sum: 40'd4, cnt: 8'd4, ovf: 1'b0});
        for (int i = 0; i < 4; i++) send0(1, 0);
        @(posedge clk); #1;

        // Reset in HOLD discards the unconsumed frame
        r0 = 1'b0;
        for (int i = 0; i < 4; i++) send0(2, 0);
        chk("pre_rst_hold_valid", ov0, 1);
        chk("pre_rst_hold_sum", s0, 8);
        pulse_rst();
        chk("rst_hold_out_valid", ov0, 0);
        chk("rst_hold_in_ready", rdy0, 1);
        r0 = 1'b1;
        q0.push_back('{sum: 40'd4, cnt: 8'd4, ovf: 1'b0});
        for (int i = 0; i < 4; i++) send0(1, 0);

        // Overflow on the narrow-guard instance
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
        exp_ovf_sum = 33'h1FFFFFFFF;
`else
        exp_ovf_sum = 33'h1FFF80004;
`endif
        q1.push_back('{sum: {7'd0, exp_ovf_sum}, cnt: 8'd4, ovf: 1'b1});
        send1(32'hFFFE0001, 0); send1(32'hFFFE0001, 0);
        chk("pre_ovf_flag", of1, 0);
        send1(32'hFFFE0001, 0);
        chk("ovf_flag_set", of1, 1);
        send1(32'hFFFE0001, 0);

        repeat (5) @(posedge clk);
        #1;
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
